// File: rtl/dac_arb_ctrl.sv
// Round-robin arbiter sharing the DAC data register between two requesters, with a minimum hold between updates.
// Latency: handshake in cycle T puts dac_data and the dac_upd pulse out in cycle T+1; HOLD then spans HOLD_TM cycles.
// Backpressure: rdy only in IDLE with en=1; requesters hold vld/data stable until their rdy, and nothing is dropped.
module dac_arb_ctrl #(
  parameter int DW      = 10,
  parameter int HOLD_TM = 499999
) (
  input  logic          s_clk,
  input  logic          s_rst,
  input  logic          en,
  input  logic          req0_vld,
  input  logic [DW-1:0] req0_data,
  output logic          req0_rdy,
  input  logic          req1_vld,
  input  logic [DW-1:0] req1_data,
  output logic          req1_rdy,
  output logic [DW-1:0] dac_data,
  output logic          dac_upd,
  output logic          gnt_id,
  output logic          busy
);

  // Last count value of the hold; the counter clears here instead of reaching HOLD_TM.
  localparam logic [18:0] HOLD_LAST = 19'(HOLD_TM - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [18:0]   hold_cnt_q, hold_cnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic [DW-1:0] dac_data_q, dac_data_d;
  logic          dac_upd_q, dac_upd_d;
  logic          gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;

  logic          any_vld;
  logic          sel;

  // Requester choice: a lone valid wins; under contention, the one not served last.
  always_comb begin
    any_vld = req0_vld | req1_vld;
    sel     = (req0_vld & req1_vld) ? ~last_gnt_q : req1_vld;
  end

  // Next-state and handshake logic; rdy is gated by reset so nothing is accepted while it is asserted.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_gnt_d = last_gnt_q;
    dac_data_d = dac_data_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    dac_upd_d  = 1'b0;
    req0_rdy   = 1'b0;
    req1_rdy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && any_vld && !s_rst) begin
          req0_rdy   = ~sel;
          req1_rdy   = sel;
          dac_data_d = sel ? req1_data : req0_data;
          gnt_id_d   = sel;
          last_gnt_d = sel;
          dac_upd_d  = 1'b1;
          hold_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // en is deliberately ignored here: a started hold always runs its full length.
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 19'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; last_gnt resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      dac_data_q <= '0;
      dac_upd_q  <= 1'b0;
      gnt_id_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_gnt_q <= last_gnt_d;
      dac_data_q <= dac_data_d;
      dac_upd_q  <= dac_upd_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
    end
  end

  assign dac_data = dac_data_q;
  assign dac_upd  = dac_upd_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dac_arb_ctrl.sv
// Directed bench for dac_arb_ctrl with HOLD_TM=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// A table covers single-requester, reset and contention; hand sequences cover en and late/withdrawn requests.
module tb_dac_arb_ctrl;

  localparam int DW      = 10;
  localparam int HOLD_TM = 4;

  logic          s_clk;
  logic          s_rst;
  logic          en;
  logic          req0_vld;
  logic [DW-1:0] req0_data;
  logic          req0_rdy;
  logic          req1_vld;
  logic [DW-1:0] req1_data;
  logic          req1_rdy;
  logic [DW-1:0] dac_data;
  logic          dac_upd;
  logic          gnt_id;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  dac_arb_ctrl #(.DW(DW), .HOLD_TM(HOLD_TM)) dut (
    .s_clk     (s_clk),
    .s_rst     (s_rst),
    .en        (en),
    .req0_vld  (req0_vld),
    .req0_data (req0_data),
    .req0_rdy  (req0_rdy),
    .req1_vld  (req1_vld),
    .req1_data (req1_data),
    .req1_rdy  (req1_rdy),
    .dac_data  (dac_data),
    .dac_upd   (dac_upd),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic          v0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic [DW-1:0] dat;
    logic          upd;
    logic          gnt;
    logic          bsy;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic set_row(input int i, input logic rst, input logic e, input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic r0, input logic r1,
                         input logic [DW-1:0] dat, input logic upd, input logic gnt, input logic bsy);
    tbl[i] = '{rst:rst, en:e, v0:v0, d0:d0, v1:v1, d1:d1, r0:r0, r1:r1, dat:dat, upd:upd, gnt:gnt, bsy:bsy};
  endtask

  initial begin
    // Single requester 0 with 0x155: grant, 4-cycle hold, re-grant 5 cycles later.
    set_row(0,  0,1,1,10'h155,0,10'h000, 1,0,10'h000,0,0,0);
    set_row(1,  0,1,1,10'h155,0,10'h000, 0,0,10'h155,1,0,1);
    set_row(2,  0,1,1,10'h155,0,10'h000, 0,0,10'h155,0,0,1);
    set_row(3,  0,1,1,10'h155,0,10'h000, 0,0,10'h155,0,0,1);
    set_row(4,  0,1,1,10'h155,0,10'h000, 0,0,10'h155,0,0,1);
    set_row(5,  0,1,1,10'h155,0,10'h000, 1,0,10'h155,0,0,0);
    set_row(6,  0,1,0,10'h000,0,10'h000, 0,0,10'h155,1,0,1);
    // Reset asserted mid-hold with both requesters valid.
    set_row(7,  1,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,0);
    // Contention after reset: 000, 3FF, 000, 3FF with pulses 5 apart.
    set_row(8,  0,1,1,10'h000,1,10'h3FF, 1,0,10'h000,0,0,0);
    set_row(9,  0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,1,0,1);
    set_row(10, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,1);
    set_row(11, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,1);
    set_row(12, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,1);
    set_row(13, 0,1,1,10'h000,1,10'h3FF, 0,1,10'h000,0,0,0);
    set_row(14, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h3FF,1,1,1);
    set_row(15, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h3FF,0,1,1);
    set_row(16, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h3FF,0,1,1);
    set_row(17, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h3FF,0,1,1);
    set_row(18, 0,1,1,10'h000,1,10'h3FF, 1,0,10'h3FF,0,1,0);
    set_row(19, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,1,0,1);
    set_row(20, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,1);
    set_row(21, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,1);
    set_row(22, 0,1,1,10'h000,1,10'h3FF, 0,0,10'h000,0,0,1);
    set_row(23, 0,1,1,10'h000,1,10'h3FF, 0,1,10'h000,0,0,0);
    set_row(24, 0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,1,1,1);
    set_row(25, 0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,0,1,1);
    set_row(26, 0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,0,1,1);
    set_row(27, 0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,0,1,1);
    set_row(28, 0,1,0,10'h000,0,10'h000, 0,0,10'h3FF,0,1,0);

    // Power-on reset with requests pending.
    s_rst = 1'b1; en = 1'b1;
    req0_vld = 1'b1; req0_data = 10'h2AA;
    req1_vld = 1'b1; req1_data = 10'h155;
    #2;
    chk("rst_dac_data", 32'(dac_data), 32'h0);
    chk("rst_dac_upd",  32'(dac_upd),  32'h0);
    chk("rst_gnt_id",   32'(gnt_id),   32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_rdy",      32'({req0_rdy, req1_rdy}), 32'h0);
    tick(); tick();
    s_rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      s_rst = tbl[i].rst; en = tbl[i].en;
      req0_vld = tbl[i].v0; req0_data = tbl[i].d0;
      req1_vld = tbl[i].v1; req1_data = tbl[i].d1;
      #1;
      chk($sformatf("row%0d req0_rdy", i), 32'(req0_rdy), 32'(tbl[i].r0));
      chk($sformatf("row%0d req1_rdy", i), 32'(req1_rdy), 32'(tbl[i].r1));
      chk($sformatf("row%0d dac_data", i), 32'(dac_data), 32'(tbl[i].dat));
      chk($sformatf("row%0d dac_upd", i),  32'(dac_upd),  32'(tbl[i].upd));
      chk($sformatf("row%0d gnt_id", i),   32'(gnt_id),   32'(tbl[i].gnt));
      chk($sformatf("row%0d busy", i),     32'(busy),     32'(tbl[i].bsy));
      tick();
    end
    s_rst = 1'b0;

    // Enable gating: 20 idle cycles with requester 1 waiting and en low.
    for (int k = 0; k < 20; k++) begin
      en = 1'b0; req0_vld = 1'b0; req1_vld = 1'b1; req1_data = 10'h0AA;
      #1;
      chk($sformatf("en_off%0d rdy", k), 32'({req0_rdy, req1_rdy}), 32'h0);
      chk($sformatf("en_off%0d upd", k), 32'(dac_upd), 32'h0);
      chk($sformatf("en_off%0d data", k), 32'(dac_data), 32'h3FF);
      tick();
    end
    en = 1'b1;
    #1;
    chk("en_rise_req1_rdy", 32'(req1_rdy), 32'h1);
    tick();
    en = 1'b0; req1_vld = 1'b0;
    #1;
    chk("en_grant_upd",  32'(dac_upd),  32'h1);
    chk("en_grant_data", 32'(dac_data), 32'h0AA);
    chk("en_grant_gnt",  32'(gnt_id),   32'h1);
    // Hold must last exactly 4 cycles even with en dropped.
    for (int k = 0; k < HOLD_TM; k++) begin
      chk($sformatf("en_drop_hold%0d busy", k), 32'(busy), 32'h1);
      tick();
    end
    #1;
    chk("en_drop_hold_end busy", 32'(busy), 32'h0);

    // Late arrival: requester 1 shows up during requester 0's hold.
    en = 1'b1; req0_vld = 1'b1; req0_data = 10'h011;
    #1;
    chk("late_req0_rdy", 32'(req0_rdy), 32'h1);
    tick();
    req0_vld = 1'b0; req1_vld = 1'b1; req1_data = 10'h122;
    #1;
    chk("late_first_data", 32'(dac_data), 32'h011);
    chk("late_first_gnt",  32'(gnt_id),   32'h0);
    for (int k = 0; k < HOLD_TM; k++) begin
      chk($sformatf("late_wait%0d req1_rdy", k), 32'(req1_rdy), 32'h0);
      tick();
      #1;
    end
    chk("late_grant_req1_rdy", 32'(req1_rdy), 32'h1);
    tick();
    req1_vld = 1'b0;
    #1;
    chk("late_grant_data", 32'(dac_data), 32'h122);
    chk("late_grant_upd",  32'(dac_upd),  32'h1);
    chk("late_grant_gnt",  32'(gnt_id),   32'h1);
    for (int k = 0; k < HOLD_TM; k++) tick();

    // Withdrawal: requester 0 pulses vld once with en low; last_gnt stays 1.
    en = 1'b0; req0_vld = 1'b1; req0_data = 10'h2AB;
    #1;
    chk("wd_pulse_req0_rdy", 32'(req0_rdy), 32'h0);
    tick();
    en = 1'b1; req0_vld = 1'b0;
    #1;
    chk("wd_after_rdy", 32'({req0_rdy, req1_rdy}), 32'h0);
    chk("wd_after_upd", 32'(dac_upd), 32'h0);
    tick();
    req0_vld = 1'b1; req0_data = 10'h2AB; req1_vld = 1'b1; req1_data = 10'h0CC;
    #1;
    chk("wd_data_kept",   32'(dac_data), 32'h122);
    chk("wd_contend_rdy", 32'({req0_rdy, req1_rdy}), 32'h2);
    tick();
    req0_vld = 1'b0; req1_vld = 1'b0;
    #1;
    chk("wd_contend_data", 32'(dac_data), 32'h2AB);
    chk("wd_contend_gnt",  32'(gnt_id),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dac_arb_ctrl.md
# dac_arb_ctrl

Arbiter and update scheduler for the 10-bit DAC output path. It shares the single DAC data register between two requesters, for example a waveform/ramp generator and a host/calibration writer. Grants are round-robin, and a programmable minimum hold time is enforced between DAC updates. It sits directly in front of the DAC pins: `dac_data` and `dac_upd` drive the converter interface.

## Interface
- `DW`, 10, DAC data width.
- `HOLD_TM`, 49_9999, minimum cycles the DAC value is held after an update before the next grant. Legal range 1..524287; the hold counter is fixed at 19 bits.
- `s_clk`  in  1  system clock; all logic on rising edge.
- `s_rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  grant enable; 0 blocks new grants, but a running hold completes.
- `req0_vld`  in  1  requester 0 has a value to write.
- `req0_data`  in  DW  requester 0 value; sampled on handshake.
- `req0_rdy`  out  1  requester 0 accepted this cycle; combinational.
- `req1_vld`  in  1  requester 1 has a value.
- `req1_data`  in  DW  requester 1 value.
- `req1_rdy`  out  1  requester 1 accepted this cycle; combinational.
- `dac_data`  out  DW  registered DAC code.
- `dac_upd`  out  1  one-cycle pulse in the cycle `dac_data` takes a new value.
- `gnt_id`  out  1  registered; index of the requester whose value is on `dac_data`.
- `busy`  out  1  registered; 1 while in HOLD.

## Operation
- Two states: IDLE and HOLD. Reset state is IDLE.
- **IDLE, grant selection:** when `en`=1 and at least one `vld` is high, exactly one requester is selected.
  - Only one valid: that requester is selected.
  - Both valid: the one not equal to `last_gnt` is selected.
  - `last_gnt` resets to 1, so requester 0 wins the first contention.
- **Ready:** the selected requester's `rdy`=1 in the same cycle, and the handshake occurs that cycle (`vld`&`rdy`). `rdy` is never high outside IDLE, never high when `en`=0, and never high while `s_rst`=1.
- **On handshake (clock edge ending the IDLE cycle):**
  - `dac_data` <= selected data.
  - `gnt_id` and `last_gnt` <= selected index.
  - `dac_upd` <= 1.
  - `hold_cnt` <= 0.
  - state <= HOLD, `busy` <= 1.
- **HOLD:**
  - `dac_upd` returns to 0 after one cycle.
  - `hold_cnt` increments each cycle.
  - When `hold_cnt` == HOLD_TM-1: state <= IDLE, `busy` <= 0, `hold_cnt` <= 0.
  - Requests arriving during HOLD wait, holding `vld` and data stable; they are not lost and not reordered.
- **`en`:** deassertion in HOLD does not shorten or extend the hold. In IDLE with `en`=0, the block stays in IDLE with both `rdy`=0.
- `dac_data` changes only on a handshake. Otherwise it holds its value indefinitely; no drift or wrap.
- Requester data is passed through unmodified. No arithmetic on data.
- A requester dropping `vld` in IDLE before its handshake is legal: no grant occurs, and `last_gnt` is unchanged.

## Timing
- **Reset values:** `dac_data`=0, `dac_upd`=0, `gnt_id`=0, `busy`=0, `req0_rdy`=`req1_rdy`=0, `last_gnt`=1, `hold_cnt`=0, state IDLE.
- **Reset mid-operation:** all of the above apply immediately (asynchronous). Any in-progress hold is discarded, and the first grant after release follows the rules from the reset state.
- **Handshake latency:** handshake in cycle T gives `dac_data` valid and `dac_upd`=1 in cycle T+1.
- **HOLD duration:** HOLD occupies cycles T+1..T+HOLD_TM, and the block is back in IDLE at T+HOLD_TM+1.
- **Update spacing:** minimum spacing between `dac_upd` pulses is HOLD_TM+1 cycles. This is achieved when a requester is waiting at the end of HOLD.
- **Back-to-back contention:** with both requesters continuously valid, grants alternate 0,1,0,1,…, each spaced HOLD_TM+1 cycles.

## Test plan
Benches run with HOLD_TM=4 unless noted.
- **Reset:** assert `s_rst` mid-HOLD with both `vld`=1 → outputs immediately at reset values and both `rdy`=0. After release, the first grant goes to requester 0.
- **Single requester:** `req0_vld`=1, `req0_data`=10'h155 held → `req0_rdy`=1 in cycle T; `dac_data`=10'h155, `dac_upd`=1, `gnt_id`=0 at T+1; `busy` high T+1..T+4; next `dac_upd` at T+6 (spacing 5).
- **Contention round-robin:** both valid continuously, `req0_data`=10'h000, `req1_data`=10'h3FF → `dac_data` sequence 000, 3FF, 000, 3FF; `gnt_id` alternates 0,1,0,1; pulses 5 cycles apart.
- **Enable gating:** `en`=0 with `req1_vld`=1 for 20 cycles → no `rdy`, no `dac_upd`, `dac_data` unchanged. Raising `en` → `req1_rdy` the same cycle. Dropping `en` mid-HOLD → HOLD still lasts exactly 4 cycles.
- **Late arrival / withdrawal:** `req1_vld` rises during HOLD and is granted in the first IDLE cycle. A requester pulsing `vld` for one IDLE cycle with `en`=0 → no grant, and `last_gnt` is unchanged on the next contention.
- **Long hold:** HOLD_TM=524287 → `busy` stays high for exactly 524287 cycles and the counter does not overflow.
